// File: rtl/ex_stall_operand_capture_pkg.sv
// ---------------------------------------------------------------------------
// ex_stall_operand_capture_pkg
//   Shared constants for the EX stall operand-capture block.
//   REG_ZERO     : architectural zero register address (never captured)
//   XLEN_DEF     : default data width
//   RADDR_W_DEF  : default register-address width
//   NUM_SRC_DEF  : default number of EX source operands
//   NUM_FWD_DEF  : default number of snooped forwarding stages
//   FWD_EX_MEM / FWD_MEM_WB : stage indices, 0 = youngest
// ---------------------------------------------------------------------------
package ex_stall_operand_capture_pkg;

  localparam logic [4:0] REG_ZERO    = 5'd0;
  localparam int         XLEN_DEF    = 32;
  localparam int         RADDR_W_DEF = 5;
  localparam int         NUM_SRC_DEF = 2;
  localparam int         NUM_FWD_DEF = 2;

  localparam int FWD_EX_MEM = 0;
  localparam int FWD_MEM_WB = 1;

endpackage

// File: rtl/ex_stall_operand_capture_slot.sv
// ---------------------------------------------------------------------------
// stall_operand_slot
//   Capture logic for one EX source operand. Finds the youngest forwarding
//   stage writing the operand's register, flags src_wait while that producer
//   is still a load in flight, and latches its result once it is final so the
//   value survives the producer retiring during a long stall.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   ex_stall        EX instruction held this cycle
//   ex_flush        EX instruction squashed this cycle
//   src_addr        operand register address
//   fwd_rd          per-stage destination register (stage 0 = youngest)
//   fwd_regwrite    per-stage register write enable
//   fwd_dvalid      per-stage result is final data
//   fwd_data        per-stage result
//   cap_data        captured value (registered)
//   cap_valid       cap_data holds a captured value
//   src_wait        youngest producer not yet data-valid (combinational)
// ---------------------------------------------------------------------------
module stall_operand_slot
  import ex_stall_operand_capture_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int NUM_FWD = NUM_FWD_DEF,
  parameter int RADDR_W = RADDR_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ex_stall,
  input  logic                       ex_flush,
  input  logic [RADDR_W-1:0]         src_addr,
  input  logic [NUM_FWD*RADDR_W-1:0] fwd_rd,
  input  logic [NUM_FWD-1:0]         fwd_regwrite,
  input  logic [NUM_FWD-1:0]         fwd_dvalid,
  input  logic [NUM_FWD*XLEN-1:0]    fwd_data,
  output logic [XLEN-1:0]            cap_data,
  output logic                       cap_valid,
  output logic                       src_wait
);

  logic               src_nonzero;
  logic [NUM_FWD-1:0] match;
  logic [NUM_FWD-1:0] ym_onehot;
  logic               ym_found;
  logic               ym_dvalid;
  logic [XLEN-1:0]    ym_data;
  logic               capture;
  logic [XLEN-1:0]    cap_data_reg;
  logic               cap_valid_reg;

  assign src_nonzero = (src_addr != RADDR_W'(REG_ZERO));

  for (genvar gi = 0; gi < NUM_FWD; gi++) begin : g_match
    assign match[gi] = src_nonzero && fwd_regwrite[gi] &&
                       (fwd_rd[gi*RADDR_W +: RADDR_W] == src_addr);
  end

  // Priority encoder: only the lowest-index (youngest) match is selected, so
  // an older stage's stale value can never slip in behind a pending load.
  always_comb begin
    ym_onehot = '0;
    ym_found  = 1'b0;
    for (int s = 0; s < NUM_FWD; s++) begin
      if (match[s] && !ym_found) begin
        ym_onehot[s] = 1'b1;
        ym_found     = 1'b1;
      end
    end
  end

  // One-hot AND-OR mux of the selected stage's result.
  always_comb begin
    ym_data = '0;
    for (int s = 0; s < NUM_FWD; s++) begin
      if (ym_onehot[s]) ym_data = ym_data | fwd_data[s*XLEN +: XLEN];
    end
  end

  assign ym_dvalid = |(ym_onehot & fwd_dvalid);
  assign capture   = ex_stall && !cap_valid_reg && ym_found && ym_dvalid;
  assign src_wait  = ex_stall && !cap_valid_reg && ym_found && !ym_dvalid;

  // Flush and release both clear; once captured the slot holds until then,
  // since every later downstream match is an older instruction.
  always_ff @(posedge clk) begin
    if (rst || ex_flush || !ex_stall) begin
      cap_valid_reg <= 1'b0;
      cap_data_reg  <= '0;
    end else if (capture) begin
      cap_valid_reg <= 1'b1;
      cap_data_reg  <= ym_data;
    end
  end

  assign cap_data  = cap_data_reg;
  assign cap_valid = cap_valid_reg;

endmodule

// File: rtl/ex_stall_operand_capture.sv
// ---------------------------------------------------------------------------
// ex_stall_operand_capture
//   Registered stall-hazard operand capture between ID/EX and EX. One
//   stall_operand_slot per source operand; this level only slices buses.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   ex_stall        EX instruction held this cycle
//   ex_flush        EX instruction squashed this cycle
//   src_addr        NUM_SRC operand addresses, slice i = operand i
//   fwd_rd          NUM_FWD destination registers, slice 0 = EX/MEM
//   fwd_regwrite    per-stage register write enable
//   fwd_dvalid      per-stage result is final (0 = load in flight)
//   fwd_data        per-stage results
//   cap_data        NUM_SRC captured operand values (registered)
//   cap_valid       per-operand capture valid
//   src_wait        per-operand youngest producer still pending
// ---------------------------------------------------------------------------
module ex_stall_operand_capture
  import ex_stall_operand_capture_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int NUM_SRC = NUM_SRC_DEF,
  parameter int NUM_FWD = NUM_FWD_DEF,
  parameter int RADDR_W = RADDR_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ex_stall,
  input  logic                       ex_flush,
  input  logic [NUM_SRC*RADDR_W-1:0] src_addr,
  input  logic [NUM_FWD*RADDR_W-1:0] fwd_rd,
  input  logic [NUM_FWD-1:0]         fwd_regwrite,
  input  logic [NUM_FWD-1:0]         fwd_dvalid,
  input  logic [NUM_FWD*XLEN-1:0]    fwd_data,
  output logic [NUM_SRC*XLEN-1:0]    cap_data,
  output logic [NUM_SRC-1:0]         cap_valid,
  output logic [NUM_SRC-1:0]         src_wait
);

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_slot
    stall_operand_slot #(
      .XLEN    (XLEN),
      .NUM_FWD (NUM_FWD),
      .RADDR_W (RADDR_W)
    ) u_slot (
      .clk          (clk),
      .rst          (rst),
      .ex_stall     (ex_stall),
      .ex_flush     (ex_flush),
      .src_addr     (src_addr[gi*RADDR_W +: RADDR_W]),
      .fwd_rd       (fwd_rd),
      .fwd_regwrite (fwd_regwrite),
      .fwd_dvalid   (fwd_dvalid),
      .fwd_data     (fwd_data),
      .cap_data     (cap_data[gi*XLEN +: XLEN]),
      .cap_valid    (cap_valid[gi]),
      .src_wait     (src_wait[gi])
    );
  end

endmodule

// File: tb/tb_ex_stall_operand_capture.sv
// ---------------------------------------------------------------------------
// tb_ex_stall_operand_capture
//   Directed bench: a 2-operand/2-stage instance and a 3-operand/3-stage
//   instance sharing clock and reset, checked against hand-computed values.
// ---------------------------------------------------------------------------
module tb_ex_stall_operand_capture;
  import ex_stall_operand_capture_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 2 x 2 instance
  logic        ex_stall, ex_flush;
  logic [9:0]  src_addr;
  logic [9:0]  fwd_rd;
  logic [1:0]  fwd_regwrite, fwd_dvalid;
  logic [63:0] fwd_data;
  logic [63:0] cap_data;
  logic [1:0]  cap_valid, src_wait;

  // 3 x 3 instance
  logic        ex_stall3, ex_flush3;
  logic [14:0] src_addr3;
  logic [14:0] fwd_rd3;
  logic [2:0]  fwd_regwrite3, fwd_dvalid3;
  logic [95:0] fwd_data3;
  logic [95:0] cap_data3;
  logic [2:0]  cap_valid3, src_wait3;

  int n_checks = 0;
  int n_errors = 0;

  ex_stall_operand_capture #(.XLEN(32), .NUM_SRC(2), .NUM_FWD(2), .RADDR_W(5)) dut (
    .clk(clk), .rst(rst), .ex_stall(ex_stall), .ex_flush(ex_flush),
    .src_addr(src_addr), .fwd_rd(fwd_rd), .fwd_regwrite(fwd_regwrite),
    .fwd_dvalid(fwd_dvalid), .fwd_data(fwd_data),
    .cap_data(cap_data), .cap_valid(cap_valid), .src_wait(src_wait)
  );

  ex_stall_operand_capture #(.XLEN(32), .NUM_SRC(3), .NUM_FWD(3), .RADDR_W(5)) dut3 (
    .clk(clk), .rst(rst), .ex_stall(ex_stall3), .ex_flush(ex_flush3),
    .src_addr(src_addr3), .fwd_rd(fwd_rd3), .fwd_regwrite(fwd_regwrite3),
    .fwd_dvalid(fwd_dvalid3), .fwd_data(fwd_data3),
    .cap_data(cap_data3), .cap_valid(cap_valid3), .src_wait(src_wait3)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_stage(input int s, input logic [4:0] rd, input logic rw,
                           input logic dv, input logic [31:0] data);
    fwd_rd[s*5 +: 5]       = rd;
    fwd_regwrite[s]        = rw;
    fwd_dvalid[s]          = dv;
    fwd_data[s*32 +: 32]   = data;
  endtask

  task automatic set_stage3(input int s, input logic [4:0] rd, input logic rw,
                            input logic dv, input logic [31:0] data);
    fwd_rd3[s*5 +: 5]      = rd;
    fwd_regwrite3[s]       = rw;
    fwd_dvalid3[s]         = dv;
    fwd_data3[s*32 +: 32]  = data;
  endtask

  task automatic idle_inputs();
    ex_stall = 1'b0; ex_flush = 1'b0; src_addr = '0;
    fwd_rd = '0; fwd_regwrite = '0; fwd_dvalid = '0; fwd_data = '0;
    ex_stall3 = 1'b0; ex_flush3 = 1'b0; src_addr3 = '0;
    fwd_rd3 = '0; fwd_regwrite3 = '0; fwd_dvalid3 = '0; fwd_data3 = '0;
  endtask

  initial begin
    idle_inputs();
    #1;

    // 1. reset with random inputs
    for (int c = 0; c < 2; c++) begin
      rst = 1'b1;
      ex_stall = 1'b1; ex_flush = 1'b0;
      src_addr = 10'($urandom); fwd_rd = src_addr;
      fwd_regwrite = 2'b11; fwd_dvalid = 2'b11;
      fwd_data = {$urandom, $urandom};
      ex_stall3 = 1'b1; src_addr3 = 15'($urandom); fwd_rd3 = src_addr3;
      fwd_regwrite3 = 3'b111; fwd_dvalid3 = 3'b111;
      fwd_data3 = {$urandom, $urandom, $urandom};
      tick();
      check("rst_cap_valid", 64'(cap_valid), 64'd0);
      check("rst_cap_data", cap_data, 64'd0);
      check("rst_cap_valid3", 64'(cap_valid3), 64'd0);
    end
    rst = 1'b0;
    idle_inputs();
    tick();

    // 2. basic capture from EX/MEM, then release
    ex_stall = 1'b1;
    src_addr = {5'd0, 5'd5};
    set_stage(FWD_EX_MEM, 5'd5, 1'b1, 1'b1, 32'hAAAA0001);
    settle();
    check("t2_wait_pre", 64'(src_wait), 64'd0);
    tick();
    check("t2_valid", 64'(cap_valid), 64'b01);
    check("t2_data0", 64'(cap_data[31:0]), 64'hAAAA0001);
    ex_stall = 1'b0;
    tick();
    check("t2_release_valid", 64'(cap_valid), 64'd0);
    check("t2_release_data", cap_data, 64'd0);

    // 3. load pending in EX/MEM masks an older stale value in MEM/WB
    idle_inputs();
    ex_stall = 1'b1;
    src_addr = {5'd7, 5'd0};
    set_stage(FWD_EX_MEM, 5'd7, 1'b1, 1'b0, 32'hDEAD);
    set_stage(FWD_MEM_WB, 5'd7, 1'b1, 1'b1, 32'h11);
    settle();
    check("t3_wait", 64'(src_wait), 64'b10);
    tick();
    check("t3_no_cap_valid", 64'(cap_valid), 64'd0);
    check("t3_no_cap_data", cap_data, 64'd0);
    set_stage(FWD_EX_MEM, 5'd0, 1'b0, 1'b0, 32'h0);
    set_stage(FWD_MEM_WB, 5'd7, 1'b1, 1'b1, 32'h22);
    settle();
    check("t3_wait_clear", 64'(src_wait), 64'd0);
    tick();
    check("t3_cap_valid", 64'(cap_valid), 64'b10);
    check("t3_cap_data1", 64'(cap_data[63:32]), 64'h22);
    set_stage(FWD_MEM_WB, 5'd0, 1'b0, 1'b0, 32'h0);
    tick();
    check("t3_hold_after_retire", 64'(cap_data[63:32]), 64'h22);
    ex_stall = 1'b0;
    tick();
    check("t3_release", 64'(cap_valid), 64'd0);

    // 4. captured value ignores later older matches
    idle_inputs();
    ex_stall = 1'b1;
    src_addr = {5'd0, 5'd3};
    set_stage(FWD_EX_MEM, 5'd3, 1'b1, 1'b1, 32'h33);
    tick();
    check("t4_cap", 64'(cap_data[31:0]), 64'h33);
    set_stage(FWD_EX_MEM, 5'd0, 1'b0, 1'b0, 32'h0);
    set_stage(FWD_MEM_WB, 5'd3, 1'b1, 1'b1, 32'h44);
    tick();
    check("t4_hold_data", 64'(cap_data[31:0]), 64'h33);
    check("t4_hold_valid", 64'(cap_valid), 64'b01);
    ex_stall = 1'b0;
    tick();
    check("t4_release_valid", 64'(cap_valid), 64'd0);
    check("t4_release_data", cap_data, 64'd0);

    // 5. x0 is never captured nor waited on
    idle_inputs();
    ex_stall = 1'b1;
    src_addr = {5'd0, 5'd0};
    set_stage(FWD_EX_MEM, 5'd0, 1'b1, 1'b0, 32'h55);
    settle();
    check("t5_x0_wait", 64'(src_wait), 64'd0);
    set_stage(FWD_EX_MEM, 5'd0, 1'b1, 1'b1, 32'h55);
    tick();
    check("t5_x0_valid", 64'(cap_valid), 64'd0);

    // same register on both operands: identical capture, same cycle
    src_addr = {5'd9, 5'd9};
    set_stage(FWD_EX_MEM, 5'd0, 1'b0, 1'b0, 32'h0);
    set_stage(FWD_MEM_WB, 5'd9, 1'b1, 1'b1, 32'h99);
    tick();
    check("t5_dual_valid", 64'(cap_valid), 64'b11);
    check("t5_dual_data", cap_data, {32'h99, 32'h99});

    // 6. flush together with stall wins
    ex_flush = 1'b1;
    tick();
    check("t6_flush_valid", 64'(cap_valid), 64'd0);
    check("t6_flush_data", cap_data, 64'd0);
    ex_flush = 1'b0;

    // reset mid-stall clears; first stall cycle after reset recaptures
    tick();
    check("t7_recap", 64'(cap_valid), 64'b11);
    rst = 1'b1;
    tick();
    check("t7_rst_valid", 64'(cap_valid), 64'd0);
    rst = 1'b0;
    set_stage(FWD_MEM_WB, 5'd9, 1'b1, 1'b1, 32'h77);
    tick();
    check("t7_post_rst_data", cap_data, {32'h77, 32'h77});
    idle_inputs();
    tick();

    // 8. 3 operands x 3 stages: youngest of three stages wins
    ex_stall3 = 1'b1;
    src_addr3 = {5'd8, 5'd6, 5'd4};
    set_stage3(0, 5'd6, 1'b1, 1'b1, 32'hA0);
    set_stage3(1, 5'd4, 1'b1, 1'b1, 32'hB0);
    set_stage3(2, 5'd6, 1'b1, 1'b1, 32'hC0);
    tick();
    check("t8_valid3", 64'(cap_valid3), 64'b011);
    check("t8_data3_0", 64'(cap_data3[31:0]), 64'hB0);
    check("t8_data3_1", 64'(cap_data3[63:32]), 64'hA0);
    check("t8_data3_2", 64'(cap_data3[95:64]), 64'h0);
    ex_stall3 = 1'b0;
    tick();
    check("t8_release3", 64'(cap_valid3), 64'd0);

    // stage 1 is the youngest match once stage 0 stops writing; its pending
    // load blocks the stage-2 value
    ex_stall3 = 1'b1;
    src_addr3 = {5'd0, 5'd0, 5'd6};
    set_stage3(0, 5'd6, 1'b0, 1'b1, 32'hA1);
    set_stage3(1, 5'd6, 1'b1, 1'b0, 32'hB1);
    set_stage3(2, 5'd6, 1'b1, 1'b1, 32'hC1);
    settle();
    check("t9_wait3", 64'(src_wait3), 64'b001);
    tick();
    check("t9_no_cap3", 64'(cap_valid3), 64'd0);
    set_stage3(1, 5'd0, 1'b0, 1'b0, 32'h0);
    tick();
    check("t9_oldest_cap3", 64'(cap_data3[31:0]), 64'hC1);
    ex_stall3 = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
